pcie_wr_serializer: RTL and testbench

//  Sits directly downstream of the PCIe RX write decoder and consumes its dual-lane (hi/lo) write interface.

---
 rtl/pcie_wr_ser_pkg.sv | 37 +++
 rtl/pcie_wr_serializer_if.sv | 49 ++++
 rtl/pcie_wr_fifo_2w1r.sv | 69 ++++++
 rtl/pcie_wr_serializer.sv | 132 +++++++++++++
 tb/tb_pcie_wr_serializer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_wr_ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_wr_ser_pkg
//  Description : Shared types and helpers for the PCIe write serializer.
//                Holds the buffered write entry layout, its width, and the
//                lane ordering rule for dual-lane RX writes.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcie_wr_ser_pkg;

    // Byte address width of the memory write path. Mirrors the value in
    // dma_defs.vh so that this slice stays self-contained.
    localparam int MEM_ADDR_BITS = 32;

    // One buffered write, as issued on the single-port memory interface.
    typedef struct packed {
        logic [1:0]               if_sel;
        logic [3:0]               mem_sel;
        logic [MEM_ADDR_BITS-1:0] addr;
        logic [31:0]              data;
        logic [3:0]               mask;
    } wr_entry_t;

    localparam int ENTRY_BITS = $bits(wr_entry_t);

    // Returns 1 when the hi lane must be issued before the lo lane.
    // Smaller address goes first; on a tie lo wins, so only a strictly
    // smaller hi address puts hi first.
    function automatic logic lane_order(
        input logic [MEM_ADDR_BITS-1:0] addr_lo,
        input logic [MEM_ADDR_BITS-1:0] addr_hi
    );
        return (addr_hi < addr_lo);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_wr_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_wr_serializer_if
//  Description : Bus bundle for the PCIe write serializer.
//                wr_*     : dual-lane (hi/lo) write strobes from the RX decoder
//                mem_wr_* : single-port valid/ready memory write interface
//                Modport slave  = serializer view (consumes wr_*, drives mem_wr_*)
//                Modport master = surrounding logic view (drives wr_*, rdy)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pcie_wr_serializer_if;

    logic [1:0]                                 wr_if_select;
    logic [3:0]                                 wr_mem_select;
    logic [pcie_wr_ser_pkg::MEM_ADDR_BITS-1:0]  wr_addr_hi;
    logic [pcie_wr_ser_pkg::MEM_ADDR_BITS-1:0]  wr_addr_lo;
    logic [31:0]                                wr_data_hi;
    logic [31:0]                                wr_data_lo;
    logic [3:0]                                 wr_mask_hi;
    logic [3:0]                                 wr_mask_lo;
    logic                                       wr_en_hi;
    logic                                       wr_en_lo;

    logic [1:0]                                 mem_wr_if_select;
    logic [3:0]                                 mem_wr_mem_select;
    logic [pcie_wr_ser_pkg::MEM_ADDR_BITS-1:0]  mem_wr_addr;
    logic [31:0]                                mem_wr_data;
    logic [3:0]                                 mem_wr_mask;
    logic                                       mem_wr_en;
    logic                                       mem_wr_rdy;

    modport slave (
        input  wr_if_select, wr_mem_select, wr_addr_hi, wr_addr_lo,
               wr_data_hi, wr_data_lo, wr_mask_hi, wr_mask_lo,
               wr_en_hi, wr_en_lo, mem_wr_rdy,
        output mem_wr_if_select, mem_wr_mem_select, mem_wr_addr,
               mem_wr_data, mem_wr_mask, mem_wr_en
    );

    modport master (
        output wr_if_select, wr_mem_select, wr_addr_hi, wr_addr_lo,
               wr_data_hi, wr_data_lo, wr_mask_hi, wr_mask_lo,
               wr_en_hi, wr_en_lo, mem_wr_rdy,
        input  mem_wr_if_select, mem_wr_mem_select, mem_wr_addr,
               mem_wr_data, mem_wr_mask, mem_wr_en
    );

endinterface
`default_nettype wire

// File: rtl/pcie_wr_fifo_2w1r.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_wr_fifo_2w1r
//  Description : FIFO with up to two writes and one read per cycle, plus an
//                occupancy count. The caller guarantees no overflow/underflow.
//                Head entry is read straight from the storage flops.
//  Ports       : pcie_clk, rst        clock, sync active-high reset
//                wr_n                 number of entries written (0..2)
//                wr_data0 / wr_data1  first / second entry written
//                rd_en                pop the head entry
//                rd_data              head entry
//                count                entries held
//  Revision    : 1.0 - initial release
// ============================================================================
module pcie_wr_fifo_2w1r #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  wire logic                     pcie_clk,
    input  wire logic                     rst,
    input  wire logic [1:0]               wr_n,
    input  wire logic [WIDTH-1:0]         wr_data0,
    input  wire logic [WIDTH-1:0]         wr_data1,
    input  wire logic                     rd_en,
    output logic [WIDTH-1:0]              rd_data,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PTR_BITS   = $clog2(DEPTH);
    localparam int COUNT_BITS = PTR_BITS + 1;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [PTR_BITS-1:0] r_wr_ptr;
    logic [PTR_BITS-1:0] r_rd_ptr;
    logic [COUNT_BITS-1:0] r_count;
    logic [PTR_BITS-1:0] w_wr_ptr_p1;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    assign w_wr_ptr_p1 = r_wr_ptr + PTR_BITS'(1);

    // Storage carries no reset: occupancy alone says what is valid.
    always_ff @(posedge pcie_clk) begin
        if (wr_n != 2'd0) begin
            r_mem[r_wr_ptr] <= wr_data0;
        end
        if (wr_n == 2'd2) begin
            r_mem[w_wr_ptr_p1] <= wr_data1;
        end
    end

    always_ff @(posedge pcie_clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_BITS'(wr_n);
            if (rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            end
            r_count <= r_count + COUNT_BITS'(wr_n) - COUNT_BITS'(rd_en);
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/pcie_wr_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_wr_serializer
//  Description : Buffers dual-lane (hi/lo) PCIe RX writes and issues them one
//                per cycle, lowest address first, on a valid/ready memory
//                write port. Overflow drops the whole cycle's writes (the RX
//                path cannot stall) and is counted.
//  Ports       : pcie_clk, rst          clock, sync active-high reset
//                bus (slave)            wr_* lanes in, mem_wr_* port out
//                fill_level             buffered entry count
//                overflow_sticky        set on first drop, cleared by rst
//                drop_cnt               dropped entries, saturating
//                stat_wr_drop           1-cycle pulse per dropping cycle
//  Config      : PCIE_WR_SER_MASK_FILTER_EN - when defined, a lane whose byte
//                mask is all zero is ignored even if its strobe is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcie_wr_serializer
    import pcie_wr_ser_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int CNT_BITS = 16
) (
    input  wire logic                  pcie_clk,
    input  wire logic                  rst,
    pcie_wr_serializer_if.slave        bus,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       overflow_sticky,
    output logic [CNT_BITS-1:0]        drop_cnt,
    output logic                       stat_wr_drop
);

    localparam int FILL_BITS = $clog2(DEPTH) + 1;

    wr_entry_t             w_ent_hi;
    wr_entry_t             w_ent_lo;
    wr_entry_t             w_first;
    wr_entry_t             w_second;
    wr_entry_t             w_head;
    logic                  w_en_hi;
    logic                  w_en_lo;
    logic                  w_hi_first;
    logic [1:0]            w_npush;
    logic [1:0]            w_acc_n;
    logic [FILL_BITS:0]    w_fill_after;
    logic                  w_drop;
    logic                  w_out_valid;
    logic                  w_pop;
    logic [CNT_BITS:0]     w_cnt_sum;
    logic [FILL_BITS-1:0]  w_fill;

    logic                  r_overflow_sticky;
    logic [CNT_BITS-1:0]   r_drop_cnt;
    logic                  r_stat_wr_drop;

`ifdef PCIE_WR_SER_MASK_FILTER_EN
    assign w_en_hi = bus.wr_en_hi && (bus.wr_mask_hi != 4'b0000);
    assign w_en_lo = bus.wr_en_lo && (bus.wr_mask_lo != 4'b0000);
`else
    assign w_en_hi = bus.wr_en_hi;
    assign w_en_lo = bus.wr_en_lo;
`endif

    // Lane entries and issue ordering. With a single active lane that lane
    // goes in slot 0; slot 1 is then ignored by the FIFO.
    always_comb begin
        w_ent_hi   = '{if_sel: bus.wr_if_select, mem_sel: bus.wr_mem_select,
                       addr: bus.wr_addr_hi, data: bus.wr_data_hi, mask: bus.wr_mask_hi};
        w_ent_lo   = '{if_sel: bus.wr_if_select, mem_sel: bus.wr_mem_select,
                       addr: bus.wr_addr_lo, data: bus.wr_data_lo, mask: bus.wr_mask_lo};
        w_hi_first = w_en_hi && (!w_en_lo || lane_order(bus.wr_addr_lo, bus.wr_addr_hi));
        w_first    = w_hi_first ? w_ent_hi : w_ent_lo;
        w_second   = w_hi_first ? w_ent_lo : w_ent_hi;
    end

    // Admission is all-or-nothing against the current fill; a pop in the
    // same cycle does not free space for this cycle's push.
    assign w_npush      = {1'b0, w_en_hi} + {1'b0, w_en_lo};
    assign w_fill_after = {1'b0, w_fill} + (FILL_BITS + 1)'(w_npush);
    assign w_drop       = (w_npush != 2'd0) && (w_fill_after > (FILL_BITS + 1)'(DEPTH));
    assign w_acc_n      = w_drop ? 2'd0 : w_npush;

    pcie_wr_fifo_2w1r #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_BITS)
    ) u_fifo (
        .pcie_clk (pcie_clk),
        .rst      (rst),
        .wr_n     (w_acc_n),
        .wr_data0 (w_first),
        .wr_data1 (w_second),
        .rd_en    (w_pop),
        .rd_data  (w_head),
        .count    (w_fill)
    );

    // The FIFO head comes straight from storage flops, so a push at N is
    // visible at N+1 and the fields cannot move while rd_ptr is stalled.
    // rst forces the port idle in the very cycle it is asserted.
    assign w_out_valid = (w_fill != '0) && !rst;
    assign w_pop       = w_out_valid && bus.mem_wr_rdy;

    assign bus.mem_wr_en         = w_out_valid;
    assign bus.mem_wr_if_select  = w_out_valid ? w_head.if_sel  : '0;
    assign bus.mem_wr_mem_select = w_out_valid ? w_head.mem_sel : '0;
    assign bus.mem_wr_addr       = w_out_valid ? w_head.addr    : '0;
    assign bus.mem_wr_data       = w_out_valid ? w_head.data    : '0;
    assign bus.mem_wr_mask       = w_out_valid ? w_head.mask    : '0;

    assign w_cnt_sum = {1'b0, r_drop_cnt} + (CNT_BITS + 1)'(w_npush);

    always_ff @(posedge pcie_clk) begin
        if (rst) begin
            r_overflow_sticky <= 1'b0;
            r_drop_cnt        <= '0;
            r_stat_wr_drop    <= 1'b0;
        end else begin
            r_stat_wr_drop <= w_drop;
            if (w_drop) begin
                r_overflow_sticky <= 1'b1;
                r_drop_cnt        <= w_cnt_sum[CNT_BITS] ? '1 : w_cnt_sum[CNT_BITS-1:0];
            end
        end
    end

    assign fill_level      = w_fill;
    assign overflow_sticky = r_overflow_sticky;
    assign drop_cnt        = r_drop_cnt;
    assign stat_wr_drop    = r_stat_wr_drop;

endmodule
`default_nettype wire

// File: tb/tb_pcie_wr_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcie_wr_serializer
//  Description : Self-checking bench for pcie_wr_serializer. Directed cases
//                followed by randomized lane traffic, checked every cycle
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_wr_serializer;
    import pcie_wr_ser_pkg::*;

    localparam int DEPTH     = 16;
    localparam int CNT_BITS  = 16;
    localparam int FILL_BITS = $clog2(DEPTH) + 1;

    logic                 pcie_clk = 1'b0;
    logic                 rst;
    logic [FILL_BITS-1:0] fill_level;
    logic                 overflow_sticky;
    logic [CNT_BITS-1:0]  drop_cnt;
    logic                 stat_wr_drop;

    always #5 pcie_clk = ~pcie_clk;

    pcie_wr_serializer_if bus ();

    pcie_wr_serializer #(
        .DEPTH    (DEPTH),
        .CNT_BITS (CNT_BITS)
    ) u_dut (
        .pcie_clk        (pcie_clk),
        .rst             (rst),
        .bus             (bus.slave),
        .fill_level      (fill_level),
        .overflow_sticky (overflow_sticky),
        .drop_cnt        (drop_cnt),
        .stat_wr_drop    (stat_wr_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: ordered queue of pending writes plus drop statistics.
    wr_entry_t m_q[$];
    int        m_cnt    = 0;
    bit        m_sticky = 1'b0;
    bit        m_stat   = 1'b0;

    task automatic compare_outputs();
        bit        en;
        wr_entry_t e;
        en = (m_q.size() != 0) && !rst;
        e  = en ? m_q[0] : '0;
        check("mem_wr_en",    bus.mem_wr_en,         en);
        check("mem_wr_if",    bus.mem_wr_if_select,  e.if_sel);
        check("mem_wr_mem",   bus.mem_wr_mem_select, e.mem_sel);
        check("mem_wr_addr",  bus.mem_wr_addr,       e.addr);
        check("mem_wr_data",  bus.mem_wr_data,       e.data);
        check("mem_wr_mask",  bus.mem_wr_mask,       e.mask);
        check("fill_level",   fill_level,            m_q.size());
        check("overflow_sticky", overflow_sticky,    m_sticky);
        check("drop_cnt",     drop_cnt,              m_cnt);
        check("stat_wr_drop", stat_wr_drop,          m_stat);
    endtask

    task automatic model_step();
        bit        en_lo, en_hi;
        int        n, sz;
        wr_entry_t e_lo, e_hi;
        if (rst) begin
            m_q.delete();
            m_cnt = 0; m_sticky = 0; m_stat = 0;
            return;
        end
        en_lo = bus.wr_en_lo;
        en_hi = bus.wr_en_hi;
`ifdef PCIE_WR_SER_MASK_FILTER_EN
        if (bus.wr_mask_lo == 4'b0000) en_lo = 0;
        if (bus.wr_mask_hi == 4'b0000) en_hi = 0;
`endif
        e_lo = '{bus.wr_if_select, bus.wr_mem_select, bus.wr_addr_lo, bus.wr_data_lo, bus.wr_mask_lo};
        e_hi = '{bus.wr_if_select, bus.wr_mem_select, bus.wr_addr_hi, bus.wr_data_hi, bus.wr_mask_hi};
        n  = int'(en_lo) + int'(en_hi);
        sz = m_q.size();
        m_stat = 0;
        if (sz != 0 && bus.mem_wr_rdy) void'(m_q.pop_front());
        if (n != 0 && sz + n > DEPTH) begin
            m_stat   = 1;
            m_sticky = 1;
            m_cnt    = (m_cnt + n > 2**CNT_BITS - 1) ? 2**CNT_BITS - 1 : m_cnt + n;
        end else if (en_lo && en_hi) begin
            if (e_hi.addr < e_lo.addr) begin m_q.push_back(e_hi); m_q.push_back(e_lo); end
            else                       begin m_q.push_back(e_lo); m_q.push_back(e_hi); end
        end else if (en_lo) m_q.push_back(e_lo);
        else if (en_hi)     m_q.push_back(e_hi);
    endtask

    task automatic idle_lanes();
        bus.wr_en_hi = 0;
        bus.wr_en_lo = 0;
    endtask

    task automatic set_lane(input bit hi, input logic [MEM_ADDR_BITS-1:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        if (hi) begin bus.wr_addr_hi = a; bus.wr_data_hi = d; bus.wr_mask_hi = m; bus.wr_en_hi = 1; end
        else    begin bus.wr_addr_lo = a; bus.wr_data_lo = d; bus.wr_mask_lo = m; bus.wr_en_lo = 1; end
    endtask

    // One clock: check at the falling edge, advance the model with the
    // inputs in force, then release the lanes just after the rising edge.
    task automatic tick();
        @(negedge pcie_clk);
        compare_outputs();
        model_step();
        @(posedge pcie_clk);
        #1;
        idle_lanes();
    endtask

    initial begin
        bus.wr_if_select = 2'd1; bus.wr_mem_select = 4'd3;
        bus.wr_addr_hi = '0; bus.wr_addr_lo = '0;
        bus.wr_data_hi = '0; bus.wr_data_lo = '0;
        bus.wr_mask_hi = 4'hF; bus.wr_mask_lo = 4'hF;
        idle_lanes();
        bus.mem_wr_rdy = 1;
        rst = 1;
        #1;
        repeat (2) tick();
        rst = 0;
        check("reset_fill", fill_level, 0);
        check("reset_en",   bus.mem_wr_en, 0);

        // Single lo write: visible one cycle later
        set_lane(0, 32'h10, 32'hA5A5_A5A5, 4'hF);
        tick();
        check("single_en",   bus.mem_wr_en, 1);
        check("single_addr", bus.mem_wr_addr, 32'h10);
        check("single_data", bus.mem_wr_data, 32'hA5A5_A5A5);
        tick();

        // Dual write, hi has the lower address
        set_lane(1, 32'h20, 32'h1111_0000, 4'hF);
        set_lane(0, 32'h24, 32'h2222_0000, 4'hF);
        tick();
        check("dual_first",  bus.mem_wr_addr, 32'h20);
        tick();
        check("dual_second", bus.mem_wr_addr, 32'h24);
        tick();

        // Dual write, lo has the lower address
        set_lane(0, 32'h30, 32'h3333_0000, 4'hF);
        set_lane(1, 32'h34, 32'h4444_0000, 4'hF);
        tick();
        check("swap_first",  bus.mem_wr_addr, 32'h30);
        tick();
        check("swap_second", bus.mem_wr_addr, 32'h34);
        tick();

        // Stall with three dual writes, then drain
        bus.mem_wr_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            set_lane(1, 32'h100 + 32'(i * 8), 32'(i), 4'hF);
            set_lane(0, 32'h104 + 32'(i * 8), 32'(i + 16), 4'hF);
            tick();
        end
        tick();
        check("stall_fill", fill_level, 6);
        check("stall_addr", bus.mem_wr_addr, 32'h100);
        bus.mem_wr_rdy = 1;
        repeat (8) tick();

        // Overflow: 8 dual cycles fill DEPTH, the 9th is dropped
        bus.mem_wr_rdy = 0;
        for (int i = 0; i < 9; i++) begin
            set_lane(0, 32'h200 + 32'(i * 8), 32'(i), 4'hF);
            set_lane(1, 32'h204 + 32'(i * 8), 32'(i), 4'hF);
            tick();
            if (i == 7) check("ovf_full", fill_level, 16);
        end
        check("ovf_stat",   stat_wr_drop, 1);
        check("ovf_cnt",    drop_cnt, 2);
        check("ovf_sticky", overflow_sticky, 1);
        tick();

        // Reset with five entries buffered
        bus.mem_wr_rdy = 1;
        repeat (20) tick();
        bus.mem_wr_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            set_lane(0, 32'h300 + 32'(i * 8), 32'(i), 4'hF);
            if (i < 2) set_lane(1, 32'h304 + 32'(i * 8), 32'(i), 4'hF);
            tick();
        end
        check("prerst_fill", fill_level, 5);
        rst = 1;
        tick();
        rst = 0;
        check("rst_fill", fill_level, 0);
        check("rst_en",   bus.mem_wr_en, 0);
        check("rst_cnt",  drop_cnt, 0);
        bus.mem_wr_rdy = 1;

        // Zero-mask lane write
        set_lane(0, 32'h40, 32'hDEAD_BEEF, 4'h0);
        tick();
        tick();

        // Randomized traffic with bursty backpressure and occasional reset
        for (int c = 0; c < 4000; c++) begin
            bit slow;
            slow = ((c / 150) % 2) == 1;
            bus.mem_wr_rdy    = slow ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            rst               = ($urandom_range(0, 599) == 0);
            bus.wr_if_select  = 2'($urandom);
            bus.wr_mem_select = 4'($urandom);
            if ($urandom_range(0, 2) != 0)
                set_lane(0, 32'($urandom_range(0, 7) * 4), $urandom,
                         ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom));
            if ($urandom_range(0, 2) != 0)
                set_lane(1, 32'($urandom_range(0, 7) * 4), $urandom,
                         ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom));
            tick();
        end
        rst = 0;
        bus.mem_wr_rdy = 1;
        repeat (DEPTH + 2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
